// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter slice.
package rf_wb_arbiter_pkg;

    localparam int unsigned REG_NUM        = 32;
    localparam int unsigned ADDR_W_DEFAULT = 5;
    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam int unsigned WB_EXU = 0;
    localparam int unsigned WB_LSU = 1;

    typedef enum logic {
        RR_EXU = 1'b0,
        RR_LSU = 1'b1
    } rr_sel_e;

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Busy scoreboard: one bit per register, set at issue, cleared when the write lands.
module rf_scoreboard #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rs1,
    input  logic [ADDR_W-1:0]        issue_rs2,
    input  logic [ADDR_W-1:0]        issue_rd,
    input  logic                     issue_wr,
    output logic                     issue_ready,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    output logic [(1<<ADDR_W)-1:0]   busy
);

    logic [(1<<ADDR_W)-1:0] busy_q;
    logic [(1<<ADDR_W)-1:0] busy_d;
    logic                   set_en;

    assign issue_ready = !(busy_q[issue_rs1] | busy_q[issue_rs2] | (issue_wr & busy_q[issue_rd]));
    assign set_en      = issue_valid & issue_ready & issue_wr & (issue_rd != '0);
    assign busy        = busy_q;

    // Set is applied after clear so a same-register collision leaves the bit busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for the integer register file with registered write port.
// Optional performance counters are enabled by defining RF_WB_ARB_PERF_EN.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_rs1,
    input  logic [ADDR_W-1:0]      issue_rs2,
    input  logic [ADDR_W-1:0]      issue_rd,
    input  logic                   issue_wr,
    output logic                   issue_ready,
    input  logic                   wb0_valid,
    input  logic [ADDR_W-1:0]      wb0_rd,
    input  logic [DATA_W-1:0]      wb0_data,
    output logic                   wb0_ready,
    input  logic                   wb1_valid,
    input  logic [ADDR_W-1:0]      wb1_rd,
    input  logic [DATA_W-1:0]      wb1_data,
    output logic                   wb1_ready,
    output logic                   rf_wen,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic [(1<<ADDR_W)-1:0] busy
`ifdef RF_WB_ARB_PERF_EN
    ,
    output logic [31:0]            perf_grant0,
    output logic [31:0]            perf_grant1,
    output logic [31:0]            perf_conflict
`endif
);

    rr_sel_e           rr_q;
    logic [1:0]        grant;
    logic              contend;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;

    assign contend = wb0_valid & wb1_valid;

    // Grants are forced low during reset so no handshake can complete.
    always_comb begin
        grant    = '0;
        win_rd   = wb0_rd;
        win_data = wb0_data;
        if (rst) begin
            if (wb0_valid && (!wb1_valid || rr_q == RR_EXU)) begin
                grant[WB_EXU] = 1'b1;
            end else if (wb1_valid) begin
                grant[WB_LSU] = 1'b1;
                win_rd        = wb1_rd;
                win_data      = wb1_data;
            end
        end
    end

    assign wb0_ready = grant[WB_EXU];
    assign wb1_ready = grant[WB_LSU];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= RR_EXU;
        end else if (contend) begin
            rr_q <= (rr_q == RR_EXU) ? RR_LSU : RR_EXU;
        end
    end

    // x0 writes complete the handshake but never raise the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= 1'b0;
            if (grant != '0) begin
                rf_wen   <= (win_rd != '0);
                rf_waddr <= win_rd;
                rf_wdata <= win_data;
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_wr    (issue_wr),
        .issue_ready (issue_ready),
        .clr_en      (rf_wen),
        .clr_addr    (rf_waddr),
        .busy        (busy)
    );

`ifdef RF_WB_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (grant[WB_EXU]) perf_grant0   <= perf_grant0 + 32'd1;
            if (grant[WB_LSU]) perf_grant1   <= perf_grant1 + 32'd1;
            if (contend)       perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (optionally with RF_WB_ARB_PERF_EN).
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_wr;
    logic        issue_ready;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_data, wb1_data;
    logic        wb0_ready, wb1_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
`ifdef RF_WB_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .ADDR_W (5),
        .DATA_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_wr    (issue_wr),
        .issue_ready (issue_ready),
        .wb0_valid   (wb0_valid),
        .wb0_rd      (wb0_rd),
        .wb0_data    (wb0_data),
        .wb0_ready   (wb0_ready),
        .wb1_valid   (wb1_valid),
        .wb1_rd      (wb1_rd),
        .wb1_data    (wb1_data),
        .wb1_ready   (wb1_ready),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy)
`ifdef RF_WB_ARB_PERF_EN
        ,
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1),
        .perf_conflict (perf_conflict)
`endif
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_wr = 1'b0;
        wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle_inputs();
        wb0_valid = 1'b1; wb0_rd = 5'd4;
        #2;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %h exp 0", rf_wen); end
        checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %h exp 0", rf_waddr); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h exp 0", rf_wdata); end
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
        checks++; if (wb0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_gated got %h exp 0", wb0_ready); end
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset_mid_write;
        issue_valid = 1'b1; issue_rd = 5'd5; issue_wr = 1'b1;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rmw_issue_ready got %h exp 1", issue_ready); end
        next_cycle();
        issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = '0;
        wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'h0000_0055;
        wb1_valid = 1'b1; wb1_rd = 5'd6; wb1_data = 32'h0000_0066;
        #1;
        checks++; if (busy !== 32'h0000_0020) begin errors++; $display("FAIL rmw_busy5 got %h exp 00000020", busy); end
        checks++; if ({wb0_ready, wb1_ready} !== 2'b10) begin errors++; $display("FAIL rmw_grant got %b exp 10", {wb0_ready, wb1_ready}); end
        next_cycle();
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5) begin errors++; $display("FAIL rmw_write got wen %h addr %0d exp wen 1 addr 5", rf_wen, rf_waddr); end
        rst = 1'b0;
        #1;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rmw_wen_cleared got %h exp 0", rf_wen); end
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL rmw_busy_cleared got %h exp 0", busy); end
        checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL rmw_outreg got %h %h exp 0 0", rf_waddr, rf_wdata); end
        checks++; if ({wb0_ready, wb1_ready} !== 2'b00) begin errors++; $display("FAIL rmw_ready_in_reset got %b exp 00", {wb0_ready, wb1_ready}); end
        next_cycle();
        rst = 1'b1;
        #1;
        checks++; if ({wb0_ready, wb1_ready} !== 2'b10) begin errors++; $display("FAIL rmw_ptr_reset got %b exp 10", {wb0_ready, wb1_ready}); end
        next_cycle();
        checks++; if ({wb0_ready, wb1_ready} !== 2'b01) begin errors++; $display("FAIL rmw_ptr_toggle got %b exp 01", {wb0_ready, wb1_ready}); end
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_single_exu;
        issue_valid = 1'b1; issue_rd = 5'd7; issue_wr = 1'b1;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL exu_issue_ready got %h exp 1", issue_ready); end
        next_cycle();
        idle_inputs();
        wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL exu_busy_set got %h exp 00000080", busy); end
        checks++; if (wb0_ready !== 1'b1) begin errors++; $display("FAIL exu_ready got %h exp 1", wb0_ready); end
        next_cycle();
        wb0_valid = 1'b0;
        #1;
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL exu_write got wen %h addr %0d data %h exp 1 7 deadbeef", rf_wen, rf_waddr, rf_wdata); end
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL exu_busy_during_write got %h exp 1", busy[7]); end
        next_cycle();
        checks++; if (rf_wen !== 1'b0 || busy !== 32'd0) begin errors++; $display("FAIL exu_clear got wen %h busy %h exp 0 0", rf_wen, busy); end
    endtask

    task automatic test_contention;
        logic [1:0] exp_rdy;
        logic [4:0] exp_addr;
        wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h0000_00A1;
        wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'h0000_00B2;
        for (int i = 0; i < 4; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_addr = (i % 2 == 1) ? 5'd1 : 5'd2;
            #1;
            checks++; if ({wb0_ready, wb1_ready} !== exp_rdy) begin
                errors++; $display("FAIL contend_grant%0d got %b exp %b", i, {wb0_ready, wb1_ready}, exp_rdy); end
            if (i > 0) begin
                checks++; if (rf_wen !== 1'b1 || rf_waddr !== exp_addr) begin
                    errors++; $display("FAIL contend_write%0d got wen %h addr %0d exp 1 %0d", i, rf_wen, rf_waddr, exp_addr); end
            end
            next_cycle();
        end
        idle_inputs();
        #1;
        checks++; if (rf_waddr !== 5'd2 || rf_wdata !== 32'h0000_00B2) begin
            errors++; $display("FAIL contend_last got addr %0d data %h exp 2 000000b2", rf_waddr, rf_wdata); end
`ifdef RF_WB_ARB_PERF_EN
        checks++; if (perf_conflict !== 32'd6) begin errors++; $display("FAIL perf_conflict got %0d exp 6", perf_conflict); end
        checks++; if (perf_grant0 !== 32'd4 || perf_grant1 !== 32'd3) begin
            errors++; $display("FAIL perf_grants got %0d %0d exp 4 3", perf_grant0, perf_grant1); end
`endif
        next_cycle();
    endtask

    task automatic test_hazard;
        issue_valid = 1'b1; issue_rd = 5'd3; issue_wr = 1'b1;
        next_cycle();
        issue_rs1 = 5'd3; issue_rd = 5'd0; issue_wr = 1'b0;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL hazard_raw got %h exp 0", issue_ready); end
        next_cycle();
        issue_rs1 = 5'd0; issue_rd = 5'd3; issue_wr = 1'b1;
        wb1_valid = 1'b1; wb1_rd = 5'd3; wb1_data = 32'h0000_0333;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL hazard_waw got %h exp 0", issue_ready); end
        checks++; if (wb1_ready !== 1'b1) begin errors++; $display("FAIL hazard_wb1_ready got %h exp 1", wb1_ready); end
        next_cycle();
        wb1_valid = 1'b0;
        issue_rs2 = 5'd3; issue_rd = 5'd0; issue_wr = 1'b0;
        #1;
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3) begin errors++; $display("FAIL hazard_write got wen %h addr %0d exp 1 3", rf_wen, rf_waddr); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL hazard_still_blocked got %h exp 0", issue_ready); end
        next_cycle();
        checks++; if (issue_ready !== 1'b1 || busy !== 32'd0) begin errors++; $display("FAIL hazard_release got ready %h busy %h exp 1 0", issue_ready, busy); end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_collision;
        wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h0000_0099;
        #1;
        checks++; if (wb0_ready !== 1'b1 || busy[9] !== 1'b0) begin errors++; $display("FAIL coll_wb got ready %h busy9 %h exp 1 0", wb0_ready, busy[9]); end
        next_cycle();
        wb0_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9; issue_wr = 1'b1;
        #1;
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || issue_ready !== 1'b1) begin
            errors++; $display("FAIL coll_same_cycle got wen %h addr %0d ready %h exp 1 9 1", rf_wen, rf_waddr, issue_ready); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (busy !== 32'h0000_0200 || rf_wen !== 1'b0) begin errors++; $display("FAIL coll_set_wins got busy %h wen %h exp 00000200 0", busy, rf_wen); end
        next_cycle();
        checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL coll_busy_held got %h exp 1", busy[9]); end
        wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h0000_0999;
        next_cycle();
        wb0_valid = 1'b0;
        next_cycle();
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL coll_cleanup got %h exp 0", busy); end
    endtask

    task automatic test_x0;
        wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h0000_1234;
        issue_valid = 1'b1; issue_rd = 5'd0; issue_wr = 1'b1;
        #1;
        checks++; if ({wb0_ready, wb1_ready} !== 2'b01) begin errors++; $display("FAIL x0_ready got %b exp 01", {wb0_ready, wb1_ready}); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL x0_issue_ready got %h exp 1", issue_ready); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (rf_wen !== 1'b0 || busy !== 32'd0) begin errors++; $display("FAIL x0_no_write got wen %h busy %h exp 0 0", rf_wen, busy); end
        next_cycle();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_no_write_late got %h exp 0", rf_wen); end
    endtask

    task automatic test_back_to_back;
        wb0_valid = 1'b1; wb0_rd = 5'd10; wb0_data = 32'h1010_0001;
        #1;
        checks++; if (wb0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %h exp 1", wb0_ready); end
        next_cycle();
        wb0_rd = 5'd11; wb0_data = 32'h1111_0002;
        #1;
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h1010_0001) begin
            errors++; $display("FAIL b2b_first got wen %h addr %0d data %h exp 1 10 10100001", rf_wen, rf_waddr, rf_wdata); end
        checks++; if (wb0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %h exp 1", wb0_ready); end
        next_cycle();
        wb0_valid = 1'b0;
        #1;
        checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'h1111_0002) begin
            errors++; $display("FAIL b2b_second got wen %h addr %0d data %h exp 1 11 11110002", rf_wen, rf_waddr, rf_wdata); end
        next_cycle();
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL b2b_idle got %h exp 0", rf_wen); end
`ifdef RF_WB_ARB_PERF_EN
        checks++; if (perf_grant0 !== 32'd8 || perf_grant1 !== 32'd5 || perf_conflict !== 32'd6) begin
            errors++; $display("FAIL perf_final got %0d %0d %0d exp 8 5 6", perf_grant0, perf_grant1, perf_conflict); end
`endif
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_single_exu();
        test_contention();
        test_hazard();
        test_collision();
        test_x0();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and hazard scoreboard for the single-write-port integer register file in the NPC core. Two writeback requesters (EXU result, LSU load data) share the port under round-robin arbitration with a valid/ready handshake. A 32-entry busy scoreboard tracks destinations claimed at issue and gates the issue stage on RAW/WAW hazards. The write is registered, giving one cycle from handshake to the register-file write strobe.

## Interface
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, write data width
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode presents an instruction
- issue_rs1, issue_rs2, issue_rd  in  ADDR_W  source/destination addresses
- issue_wr  in  1  instruction writes issue_rd
- issue_ready  out  1  no hazard; issue accepted when issue_valid & issue_ready
- wb0_valid, wb0_rd, wb0_data / wb0_ready  in 1/ADDR_W/DATA_W / out 1  EXU writeback request
- wb1_valid, wb1_rd, wb1_data / wb1_ready  in 1/ADDR_W/DATA_W / out 1  LSU writeback request
- rf_wen  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  write address (registered)
- rf_wdata  out  DATA_W  write data (registered)
- busy  out  32  scoreboard vector, bit i = register i has a pending write

## Operation
- Reset (rst low, asynchronous): busy=0, rf_wen=0, rf_waddr=0, rf_wdata=0, rr pointer=0 (requester 0 preferred); wb0_ready/wb1_ready combinationally 0 while rst low; in-flight handshakes discarded.
- Arbitration: only one valid → granted. Both valid → requester at rr pointer granted; pointer toggles after every contended grant, unchanged on uncontended grants. Exactly one ready high per cycle at most; ready never asserted without matching valid.
- Handshake: wbN_valid & wbN_ready latches rd/data into the output register; rf_wen=1 next cycle. Requester holds valid/rd/data stable until ready.
- rd=0 handshake: accepted (ready high), rf_wen stays 0.
- Scoreboard set: issue accepted with issue_wr=1 and issue_rd≠0 → busy[issue_rd]=1 next cycle.
- Scoreboard clear: cycle with rf_wen=1 → busy[rf_waddr]=0 next cycle; clear coincides with the write landing in the register file, so a reader issuing after sees new data.
- Same-register set and clear in one cycle: set wins (busy stays 1).
- issue_ready = !(busy[rs1] | busy[rs2] | (issue_wr & busy[issue_rd])); busy[0] is constant 0. Combinational, independent of issue_valid.
- Writeback to a non-busy register is legal and written; scoreboard unchanged.

## Timing
- Handshake cycle N → rf_wen, rf_waddr, rf_wdata valid cycle N+1 → busy bit low cycle N+2.
- Back-to-back grants: one write per cycle sustained; rf_wen may stay high continuously.
- Contended throughput: alternating grants, each requester waits at most one cycle.
- Issue gating: zero-cycle combinational path busy → issue_ready.

## Configuration
- RF_WB_ARB_PERF_EN defined: adds outputs perf_grant0, perf_grant1, perf_conflict (32 bits each, reset 0, wrap at 2^32): grants per requester and cycles with both valid. Undefined: ports and counters absent, arbitration identical.

## Structure
- Shared package: REG_NUM=32, ADDR_W/DATA_W defaults, writeback requester index constants (WB_EXU=0, WB_LSU=1).
- One sub-module: rf_scoreboard (busy vector, set/clear priority, hazard compare); arbiter, rr pointer and output register in top level.

## Test plan
- Reset mid-write: wb0 handshake rd=5, assert rst next cycle → rf_wen=0, busy=0, pointer=0 immediately.
- Single EXU write: issue rd=7 wr=1, then wb0 rd=7 data=0xDEADBEEF → busy[7]=1, rf_wen=1 waddr=7 wdata=0xDEADBEEF one cycle after handshake, busy[7]=0 following cycle.
- Contention: both valid 4 cycles (rd 1 and 2) → grants 0,1,0,1; each ready high alternately; perf_conflict=4 with macro.
- Hazard: busy[3]=1, issue rs1=3 → issue_ready=0 until cycle after rf_wen for rd 3, then 1.
- Set/clear collision: rf_wen for rd 9 same cycle as issue with rd=9 → busy[9] remains 1.
- x0: wb1 rd=0 data=0x1234 → wb1_ready=1, rf_wen never asserted, busy[0]=0.
